// File: rtl/cache_line_flusher.sv
// Streams one cache line from cache_memblock to the memory arbiter over valid/ready.
// Optional CACHE_FLUSH_DIRTYMASK_EN: only words flagged in dirty_mask are written back.
//   state  | meaning
//   S_IDLE | waiting for start; latches base (and mask)
//   S_RUN  | issuing line reads and streaming words to memory
//   S_DONE | one-cycle done pulse, then back to idle
module cache_line_flusher #(
    parameter int ADDRBITS = 32,
    parameter int DATABITS = 32,
    parameter int LSBBITS  = 7
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [ADDRBITS-LSBBITS-1:0]  line_base,
`ifdef CACHE_FLUSH_DIRTYMASK_EN
    input  logic [2**(LSBBITS-2)-1:0]    dirty_mask,
`endif
    output logic                         busy,
    output logic                         done,
    output logic [LSBBITS-1:0]           line_mem_rdaddr,
    input  logic [DATABITS-1:0]          line_mem_out,
    output logic [ADDRBITS-1:0]          mem_addr,
    output logic [DATABITS-1:0]          mem_data,
    output logic [1:0]                   mem_wordlen,
    output logic                         mem_valid,
    input  logic                         mem_ready
);

    localparam int WORDS = 2**(LSBBITS-2);
    localparam int IDXW  = LSBBITS-1;
    localparam logic [IDXW-1:0] C_END = IDXW'(WORDS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                        r_state;
    logic [ADDRBITS-LSBBITS-1:0]   r_base;
    logic [IDXW-1:0]               r_rd_idx;
    logic [IDXW-1:0]               r_ack_idx;
    logic                          r_inflight;
    logic [LSBBITS-1:0]            r_rdaddr;
    logic                          r_busy;
    logic                          r_done;
    logic [DATABITS-1:0]           r_fifo [2];
    logic                          r_wptr;
    logic                          r_rptr;
    logic [1:0]                    r_count;

    logic                          w_pop;
    logic                          w_issue;
    logic [2:0]                    w_occ;
    logic [LSBBITS-1:0]            w_rdaddr;
    logic [IDXW-1:0]               w_first;
    logic [IDXW-1:0]               w_rd_next;
    logic [IDXW-1:0]               w_ack_next;

`ifdef CACHE_FLUSH_DIRTYMASK_EN
    logic [WORDS-1:0]              r_mask;

    // Lowest set mask bit at or above from_idx; C_END when none remain.
    function automatic logic [IDXW-1:0] f_seek(input logic [WORDS-1:0] m,
                                               input logic [IDXW-1:0]  from_idx);
        logic [IDXW-1:0] idx;
        idx = C_END;
        for (int j = WORDS-1; j >= 0; j--) begin
            if (m[j] && (IDXW'(j) >= from_idx)) idx = IDXW'(j);
        end
        return idx;
    endfunction

    always_comb begin
        w_first    = f_seek(dirty_mask, '0);
        w_rd_next  = f_seek(r_mask, r_rd_idx + IDXW'(1));
        w_ack_next = f_seek(r_mask, r_ack_idx + IDXW'(1));
    end
`else
    always_comb begin
        w_first    = '0;
        w_rd_next  = r_rd_idx + IDXW'(1);
        w_ack_next = r_ack_idx + IDXW'(1);
    end
`endif

    // Words already buffered or in flight after this cycle's pop; keeps the
    // 2-entry FIFO from overflowing despite the 1-cycle line read latency.
    always_comb begin
        w_pop    = mem_valid && mem_ready;
        w_occ    = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
        w_issue  = (r_state == S_RUN) && (r_rd_idx < C_END) && (w_occ < 3'd2);
        w_rdaddr = w_issue ? {r_rd_idx[IDXW-2:0], 2'b00} : r_rdaddr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_rd_idx   <= '0;
            r_ack_idx  <= '0;
            r_inflight <= 1'b0;
            r_rdaddr   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= '0;
`ifdef CACHE_FLUSH_DIRTYMASK_EN
            r_mask     <= '0;
`endif
        end else begin
            if (r_inflight) begin
                r_fifo[r_wptr] <= line_mem_out;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_count    <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
            r_inflight <= w_issue;
            r_rdaddr   <= w_rdaddr;
            if (w_issue) r_rd_idx <= w_rd_next;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base    <= line_base;
                        r_rd_idx  <= w_first;
                        r_ack_idx <= w_first;
                        r_busy    <= 1'b1;
`ifdef CACHE_FLUSH_DIRTYMASK_EN
                        r_mask    <= dirty_mask;
`endif
                        if (w_first == C_END) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_pop) begin
                        r_ack_idx <= w_ack_next;
                        if (w_ack_next == C_END) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign line_mem_rdaddr = w_rdaddr;
    assign mem_valid       = (r_count != 2'd0);
    assign mem_data        = r_fifo[r_rptr];
    assign mem_addr        = {r_base, r_ack_idx[IDXW-2:0], 2'b00};
    assign mem_wordlen     = 2'b10;

endmodule

// File: tb/tb_cache_line_flusher.sv
// Randomized bench for cache_line_flusher: line RAM model plus an expected-word queue per flush.
module tb_cache_line_flusher;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [24:0] line_base;
`ifdef CACHE_FLUSH_DIRTYMASK_EN
    logic [31:0] dirty_mask;
`endif
    logic        busy;
    logic        done;
    logic [6:0]  line_mem_rdaddr;
    logic [31:0] line_mem_out;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [1:0]  mem_wordlen;
    logic        mem_valid;
    logic        mem_ready;

    logic [31:0] line_ram [32];
    int          n_chk;
    int          n_fail;

    cache_line_flusher dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .line_base       (line_base),
`ifdef CACHE_FLUSH_DIRTYMASK_EN
        .dirty_mask      (dirty_mask),
`endif
        .busy            (busy),
        .done            (done),
        .line_mem_rdaddr (line_mem_rdaddr),
        .line_mem_out    (line_mem_out),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .mem_wordlen     (mem_wordlen),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready)
    );

    always #5 clk = ~clk;

    // Synchronous line memory: data appears the cycle after the address.
    always @(posedge clk) line_mem_out <= line_ram[line_mem_rdaddr[6:2]];

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 stalled 20 cycles, 3 random
    task automatic flush(input logic [24:0] base, input logic [31:0] mask, input int mode,
                         input int restart_at, input int abort_after);
        logic [63:0] exp_q[$];
        logic [63:0] held_v;
        int          accepts, last_acc_k, first_valid_k, n_exp;
        bit          done_seen, held, bad_lsb;
        accepts = 0; last_acc_k = 0; first_valid_k = 0;
        done_seen = 0; held = 0; bad_lsb = 0; held_v = '0;
        for (int i = 0; i < 32; i++) line_ram[i] = $urandom;
        for (int i = 0; i < 32; i++)
            if (mask[i]) exp_q.push_back({base, i[4:0], 2'b00, line_ram[i]});
        n_exp = exp_q.size();

        @(negedge clk);
        start     = 1'b1;
        line_base = base;
`ifdef CACHE_FLUSH_DIRTYMASK_EN
        dirty_mask = mask;
`endif
        mem_ready = (mode != 2);
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            if (start) line_base = base ^ 25'h1555555;
            if (k == 1) chk("busy_after_start", busy, 1);
            case (mode)
                0: mem_ready = 1'b1;
                1: mem_ready = ((k % 4) == 0) || ((k % 4) == 3);
                2: mem_ready = (k > 20);
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 2 && k == 20) begin
                chk("stall_rdaddr", line_mem_rdaddr, 7'h04);
                chk("stall_valid", mem_valid, 1);
            end
            if (held) chk("stall_hold", {mem_valid, mem_addr, mem_data}, {1'b1, held_v});
            held   = mem_valid && !mem_ready;
            held_v = {mem_addr, mem_data};
            if (line_mem_rdaddr[1:0] != 2'b00) bad_lsb = 1;
            if (mem_valid && first_valid_k == 0) first_valid_k = k;
            if (done) begin
                chk("done_timing", k, last_acc_k + 1);
                done_seen = 1;
                break;
            end
            if (mem_valid && mem_ready) begin
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else chk("word", {mem_addr, mem_data}, exp_q.pop_front());
                accepts++;
                last_acc_k = k;
                if (accepts == abort_after) break;
            end
        end
        start = 1'b0;
        chk("rdaddr_lsb", bad_lsb, 0);
        if (abort_after == 0) begin
            chk("done_seen", done_seen, 1);
            chk("accept_count", accepts, n_exp);
            if (mode == 0) chk("first_valid_k", first_valid_k, (n_exp > 0) ? 3 : 0);
            @(negedge clk);
            chk("idle_after_done", {busy, done, mem_valid}, 0);
        end
    endtask

    initial begin
        clk = 1'b0; reset_n = 1'b0; start = 1'b0; line_base = '0; mem_ready = 1'b0;
`ifdef CACHE_FLUSH_DIRTYMASK_EN
        dirty_mask = '0;
`endif
        n_chk = 0; n_fail = 0;
        for (int i = 0; i < 32; i++) line_ram[i] = $urandom;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {busy, done, mem_valid}, 0);
        chk("rst_rdaddr", line_mem_rdaddr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("wordlen", mem_wordlen, 2'b10);
        reset_n = 1'b1;

        flush(25'h0001234, '1, 0, 0, 0);
        flush(25'($urandom), '1, 1, 0, 0);
        flush(25'($urandom), '1, 2, 0, 0);
        flush(25'($urandom), '1, 0, 10, 0);
        flush(25'($urandom), '1, 3, 0, 10);

        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, mem_valid}, 0);
        chk("abort_rdaddr", line_mem_rdaddr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        flush(25'($urandom), '1, 0, 0, 0);
        flush(25'($urandom), '1, 3, 0, 0);

`ifdef CACHE_FLUSH_DIRTYMASK_EN
        flush(25'($urandom), 32'h8000_0005, 0, 0, 0);
        flush(25'($urandom), 32'h0000_0000, 0, 0, 0);
        flush(25'($urandom), $urandom, 3, 0, 0);
        flush(25'($urandom), $urandom, 1, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
